// File: rtl/seq_detect_pkg.sv
// seq_detect_pkg: shared types, defaults and helpers for the programmable sequence detector
package seq_detect_pkg;
    typedef enum logic [1:0] {EMPTY, PARTIAL, ARMED} fill_state_e;
    localparam int DEF_MAX_LEN = 8;
    localparam int DEF_CNT_W = 16;
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction
    function automatic fill_state_e fill_state(input int fill, input int len);
        return fill == 0 ? EMPTY : fill >= len ? ARMED : PARTIAL;
    endfunction
endpackage

// File: rtl/sat_counter.sv
// sat_counter: saturating up-counter; clr with inc loads 1
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] q
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else     q <= clr ? CNT_W'(inc) : inc && !(&q) ? q + CNT_W'(1) : q;
endmodule

// File: rtl/seq_detect_prog.sv
// seq_detect_prog: runtime-programmable serial pattern detector with saturating match count
module seq_detect_prog
    import seq_detect_pkg::*;
#(
    parameter int                 MAX_LEN     = DEF_MAX_LEN,
    parameter int                 LEN_W       = len_width(MAX_LEN),
    parameter int                 CNT_W       = DEF_CNT_W,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'('h0F),
    parameter int                 RST_LEN     = 4,
    parameter logic               RST_OVERLAP = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               din_valid,
    input  logic               din,
    input  logic               cfg_we,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    input  logic               cnt_clr,
    output logic               y,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               cfg_err
);
    logic [MAX_LEN-1:0] pattern, hist, hist_next, len_mask;
    logic [LEN_W-1:0]   len, fill, fill_next;
    logic [LEN_W:0]     fill_inc;
    logic               overlap, accept, cfg_ok, cfg_load, match;
    fill_state_e        st;

    // A config strobe always steals the cycle, so the stream bit is dropped.
    always_comb begin
        accept    = en & din_valid & ~cfg_we;
        cfg_ok    = cfg_len != '0 && cfg_len <= LEN_W'(MAX_LEN);
        cfg_load  = cfg_we & cfg_ok;
        hist_next = {hist[MAX_LEN-2:0], din};
        len_mask  = ~({MAX_LEN{1'b1}} << len);
        fill_inc  = {1'b0, fill} + (LEN_W+1)'(1);
        st        = fill_state(int'(fill), int'(len));
        match     = accept && fill_inc >= {1'b0, len} && ((hist_next ^ pattern) & len_mask) == '0;
        fill_next = match && !overlap ? '0 : st == ARMED ? len : fill_inc[LEN_W-1:0];
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            pattern <= RST_PATTERN;
            len     <= LEN_W'(RST_LEN);
            overlap <= RST_OVERLAP;
            hist    <= '0;
            fill    <= '0;
            y       <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            y       <= match;
            cfg_err <= cfg_we & ~cfg_ok;
            if (cfg_load) begin
                pattern <= cfg_pattern;
                len     <= cfg_len;
                overlap <= cfg_overlap;
                hist    <= '0;
                fill    <= '0;
            end else if (accept) begin
                hist <= hist_next;
                fill <= fill_next;
            end
        end

    sat_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (match),
        .clr (cnt_clr | cfg_load),
        .q   (match_cnt)
    );
endmodule
